// File: rtl/rv_div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, one trial subtract per cycle.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |rs1| < |rs2|.
module rv_div_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nx;
    logic            want_rem, neg_quo, neg_rem;
    logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
    logic [CNT_W-1:0] cnt_q;

    logic            is_signed, div_zero, early, accept, last;
    logic [XLEN-1:0] abs1, abs2;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff, rem_step, quo_step, quo_fin, rem_fin;
    logic            fits;

    always_comb begin
        is_signed = ~op[0];
        abs1      = (is_signed && rs1[XLEN-1]) ? -rs1 : rs1;
        abs2      = (is_signed && rs2[XLEN-1]) ? -rs2 : rs2;
        div_zero  = (rs2 == '0);
        accept    = (state == IDLE) && start && !flush;
        early     = 1'b0;
`ifdef DIV_EARLY_OUT_EN
        early     = !div_zero && (abs1 < abs2);
`endif
        // Low XLEN bits of the difference are exact even when shifted[XLEN] is set.
        shifted   = {rem_q, quo_q[XLEN-1]};
        fits      = (shifted >= {1'b0, dvsr_q});
        diff      = shifted[XLEN-1:0] - dvsr_q;
        rem_step  = fits ? diff : shifted[XLEN-1:0];
        quo_step  = {quo_q[XLEN-2:0], fits};
        quo_fin   = neg_quo ? -quo_step : quo_step;
        rem_fin   = neg_rem ? -rem_step : rem_step;
        last      = (cnt_q == CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = (div_zero || early) ? DONE : CALC;
            CALC: begin
                if (flush)     state_nx = IDLE;
                else if (last) state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE) && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            want_rem <= 1'b0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            result   <= '0;
        end else if (accept) begin
            want_rem <= op[1];
            neg_quo  <= is_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
            neg_rem  <= is_signed && rs1[XLEN-1];
            rem_q    <= '0;
            quo_q    <= abs1;
            dvsr_q   <= abs2;
            cnt_q    <= CNT_W'(XLEN);
            if (div_zero)   result <= op[1] ? rs1 : '1;
            else if (early) result <= op[1] ? rs1 : '0;
        end else if (state == CALC && !flush) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q - 1'b1;
            if (last) result <= want_rem ? rem_fin : quo_fin;
        end
    end

endmodule

// File: tb/tb_rv_div_unit.sv
// Directed self-checking bench for rv_div_unit (XLEN=32), with hand-computed results and latencies.
module tb_rv_div_unit;

    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [1:0]  op;
    logic [31:0] rs1, rs2;
    logic        busy, done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 0;
`else
    localparam int EARLY_LAT = 32;
`endif

    rv_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Issues one op and waits for done; latency = edges after the accepting edge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input string name);
        int lat;
        bit busy_bad;
        lat = -1;
        busy_bad = 1'b0;
        @(negedge clk); start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (done === 1'b1) begin lat = k; break; end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (result !== exp_res) begin
            n_bad++; $display("FAIL %s result: got %h expected %h", name, result, exp_res);
        end
        n_cmp++;
        if (busy_bad !== 1'b0) begin
            n_bad++; $display("FAIL %s busy_low_while_running: got %b expected 0", name, busy_bad);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL %s after_done busy/done: got %b expected 00", name, {busy, done});
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL reset busy/done: got %b expected 00", {busy, done});
        end
        n_cmp++;
        if (result !== 32'h0) begin
            n_bad++; $display("FAIL reset result: got %h expected 00000000", result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset idle_after_release: got %b expected 0", busy);
        end
    endtask

    task automatic test_unsigned;
        do_op(2'b01, 32'd100, 32'd7, 32'd14, 32, "divu_100_7");
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 32, "remu_100_7");
        do_op(2'b01, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 32, "divu_max_16");
        do_op(2'b11, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32, "remu_max_msb");
    endtask

    task automatic test_signed;
        do_op(2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32, "div_m7_2");
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32, "rem_m7_2");
        do_op(2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32, "rem_7_m2");
        do_op(2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32, "div_7_m2");
    endtask

    task automatic test_div_zero;
        do_op(2'b00, 32'd1234, 32'd0, 32'hFFFFFFFF, 0, "div_by_zero");
        do_op(2'b11, 32'd5, 32'd0, 32'd5, 0, "remu_by_zero");
        do_op(2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 0, "rem_neg_by_zero");
    endtask

    task automatic test_overflow;
        do_op(2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32, "div_overflow");
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32, "rem_overflow");
    endtask

    task automatic test_early_out;
        do_op(2'b01, 32'd3, 32'd10, 32'd0, EARLY_LAT, "divu_3_10");
        do_op(2'b11, 32'd3, 32'd10, 32'd3, EARLY_LAT, "remu_3_10");
        do_op(2'b10, 32'hFFFFFFFD, 32'd10, 32'hFFFFFFFD, EARLY_LAT, "rem_m3_10");
    endtask

    task automatic test_flush;
        bit seen;
        do_op(2'b01, 32'd100, 32'd7, 32'd14, 32, "flush_prep");
        // flush in cycle T+10
        @(negedge clk); start = 1'b1; op = 2'b01; rs1 = 32'd1000; rs2 = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL flush_mid busy/done: got %b expected 00", {busy, done});
        end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen = 1'b1; end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++; $display("FAIL flush_mid no_done: got %b expected 0", seen);
        end
        n_cmp++;
        if (result !== 32'd14) begin
            n_bad++; $display("FAIL flush_mid result_kept: got %h expected 0000000e", result);
        end
        // flush in the last CALC cycle (T+32) must not load result
        @(negedge clk); start = 1'b1; op = 2'b11; rs1 = 32'd1000; rs2 = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (31) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL flush_last busy/done: got %b expected 00", {busy, done});
        end
        n_cmp++;
        if (result !== 32'd14) begin
            n_bad++; $display("FAIL flush_last result_kept: got %h expected 0000000e", result);
        end
        // flush during the DONE cycle suppresses done
        @(negedge clk); start = 1'b1; op = 2'b01; rs1 = 32'd9; rs2 = 32'd0;
        @(posedge clk); #1; start = 1'b0; flush = 1'b1;
        #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL flush_done done_suppressed: got %b expected 0", done);
        end
        @(posedge clk); #1; flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL flush_done busy: got %b expected 0", busy);
        end
        // flush with start in IDLE drops the start
        @(negedge clk); start = 1'b1; flush = 1'b1; op = 2'b01; rs1 = 32'd50; rs2 = 32'd5;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL flush_start busy: got %b expected 0", busy);
        end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen = 1'b1; end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++; $display("FAIL flush_start no_done: got %b expected 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        int ndone, dlat;
        logic [31:0] dres;
        ndone = 0; dlat = -1; dres = '0;
        @(negedge clk); start = 1'b1; op = 2'b01; rs1 = 32'd1000; rs2 = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < 45; k++) begin
            rs1 = 32'd9; rs2 = 32'd3;
            start = (k == 4);
            if (done === 1'b1) begin
                ndone++; dlat = k; dres = result; start = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_cmp++;
        if (ndone !== 1) begin
            n_bad++; $display("FAIL extra_starts done_count: got %0d expected 1", ndone);
        end
        n_cmp++;
        if (dlat !== 32) begin
            n_bad++; $display("FAIL extra_starts latency: got %0d expected 32", dlat);
        end
        n_cmp++;
        if (dres !== 32'd333) begin
            n_bad++; $display("FAIL extra_starts result: got %0d expected 333", dres);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL extra_starts idle_at_end: got %b expected 0", busy);
        end
        do_op(2'b11, 32'd1000, 32'd3, 32'd1, 32, "start_after_done");
    endtask

    task automatic test_reset_mid;
        bit seen;
        do_op(2'b01, 32'd100, 32'd7, 32'd14, 32, "reset_prep");
        @(negedge clk); start = 1'b1; op = 2'b01; rs1 = 32'd100; rs2 = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (14) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL reset_mid busy/done: got %b expected 00", {busy, done});
        end
        n_cmp++;
        if (result !== 32'h0) begin
            n_bad++; $display("FAIL reset_mid result: got %h expected 00000000", result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) seen = 1'b1; end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid stays_idle: got %b expected 0", seen);
        end
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 32, "after_reset");
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_div_zero;
        test_overflow;
        test_early_out;
        test_flush;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
